elevator_controller: RTL and testbench

Sequential request-and-motion controller for the 8-floor elevator datapath. It latches floor and hall button presses into pending-call registers and chooses travel direction. It issues single-floor move pulses and holds the door for a fixed time. Its `call_in/call_up/call_down`, `direction` and `move` outputs drive the simulator stage directly. The simulator's `cur_floor_out` and `open` return as this block's `cur_floor` and `open` inputs.

---
 rtl/elevator_controller.sv | 116 +++++++++++
 tb/tb_elevator_controller.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_controller.sv
// Request-and-motion controller for an 8-floor elevator: latches car and hall calls,
// picks the travel direction, issues single-floor move pulses and times the door.
module elevator_controller #(
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] btn_in,
    input  logic [7:0] btn_up,
    input  logic [7:0] btn_down,
    input  logic [2:0] cur_floor,
    input  logic       open,
    output logic [7:0] call_in,
    output logic [7:0] call_up,
    output logic [7:0] call_down,
    output logic       direction,
    output logic       move,
    output logic       door_open,
    output logic       idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_STEP,
        S_DOOR
    } state_t;

    localparam logic [3:0] DOOR_LOAD = 4'(DOOR_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] door_cnt, door_cnt_nxt;
    logic       dir_nxt;
    logic [7:0] pend, floor_bit;
    logic [7:0] in_nxt, up_nxt, dn_nxt;
    logic       any, ahead_up, ahead_dn, ahead, serve;

    always_comb begin
        pend      = call_in | call_up | call_down;
        any       = |pend;
        floor_bit = 8'd1 << cur_floor;
        ahead_up  = 1'b0;
        ahead_dn  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > int'(cur_floor)) ahead_up = ahead_up | pend[i];
            if (i < int'(cur_floor)) ahead_dn = ahead_dn | pend[i];
        end
        ahead = direction ? ahead_up : ahead_dn;
    end

    // Serving a floor both clears the calls being answered and blocks re-presses of them
    // for the whole door hold, so a held button cannot cause a second stop.
    always_comb begin
        serve  = (state == S_CHECK && open) || state == S_DOOR;
        in_nxt = call_in | btn_in;
        up_nxt = call_up | (btn_up & 8'h7f);
        dn_nxt = call_down | (btn_down & 8'hfe);
        if (serve) begin
            in_nxt = in_nxt & ~floor_bit;
            if (direction) up_nxt = up_nxt & ~floor_bit;
            else           dn_nxt = dn_nxt & ~floor_bit;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_nxt    = state;
        dir_nxt      = direction;
        door_cnt_nxt = door_cnt;
        unique case (state)
            S_IDLE: if (any) state_nxt = S_CHECK;
            S_CHECK: begin
                if (open) begin
                    state_nxt    = S_DOOR;
                    door_cnt_nxt = DOOR_LOAD;
                end else if (ahead) begin
                    state_nxt = S_STEP;
                end else if (any) begin
                    dir_nxt = ~direction;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_STEP: state_nxt = S_CHECK;
            S_DOOR: begin
                if (door_cnt == 4'd0) state_nxt = S_CHECK;
                else                  door_cnt_nxt = door_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_IDLE;
            door_cnt  <= 4'd0;
            direction <= 1'b1;
            call_in   <= 8'd0;
            call_up   <= 8'd0;
            call_down <= 8'd0;
        end else begin
            state     <= state_nxt;
            door_cnt  <= door_cnt_nxt;
            direction <= dir_nxt;
            call_in   <= in_nxt;
            call_up   <= up_nxt;
            call_down <= dn_nxt;
        end
    end

    assign move      = (state == S_STEP);
    assign door_open = (state == S_DOOR);
    assign idle      = (state == S_IDLE);

endmodule

// File: tb/tb_elevator_controller.sv
// Self-checking bench for elevator_controller: a floor plant, a cycle-level reference
// model built from the call/serve rules, table vectors, directed scenarios and random traffic.
module tb_elevator_controller;

    localparam int DC = 3;
    localparam int P_IDLE = 0, P_CHECK = 1, P_STEP = 2, P_DOOR = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] btn_in = 8'd0, btn_up = 8'd0, btn_down = 8'd0;
    logic [2:0] floor = 3'd0;
    logic       floor_set_en = 1'b0;
    logic [2:0] floor_set_val = 3'd0;
    logic       open;
    logic [7:0] call_in, call_up, call_down;
    logic       direction, move, door_open, idle;

    int n_cmp = 0;
    int n_err = 0;

    elevator_controller #(.DOOR_CYCLES(DC)) dut (
        .clock(clock), .reset(reset),
        .btn_in(btn_in), .btn_up(btn_up), .btn_down(btn_down),
        .cur_floor(floor), .open(open),
        .call_in(call_in), .call_up(call_up), .call_down(call_down),
        .direction(direction), .move(move), .door_open(door_open), .idle(idle)
    );

    always #5 clock = ~clock;

    // Plant: a call exists at this floor in the travel direction -> arrival; move steps the car.
    assign open = call_in[floor] | (direction ? call_up[floor] : call_down[floor]);
    always @(posedge clock) begin
        if (floor_set_en) floor <= floor_set_val;
        else if (move)    floor <= direction ? floor + 3'd1 : floor - 3'd1;
    end

    // Reference model state.
    logic [7:0] m_in = 8'd0, m_up = 8'd0, m_dn = 8'd0;
    bit         m_dir = 1'b1;
    int         m_phase = P_IDLE;
    int         m_door_left = 0;
    int         m_floor = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int f, nf;
        bit open_now, any_p, ahead_p;
        logic [7:0] pend, bit_f;
        f       = m_floor;
        pend    = m_in | m_up | m_dn;
        bit_f   = 8'd1 << f;
        open_now = ((m_in | (m_dir ? m_up : m_dn)) & bit_f) != 8'd0;
        any_p   = pend != 8'd0;
        ahead_p = 1'b0;
        for (int g = 0; g < 8; g++)
            if (pend[g] && (m_dir ? g > f : g < f)) ahead_p = 1'b1;
        if (floor_set_en)          nf = int'(floor_set_val);
        else if (m_phase == P_STEP) nf = (m_dir ? f + 1 : f - 1) & 7;
        else                       nf = f;
        if (reset) begin
            m_in = 8'd0; m_up = 8'd0; m_dn = 8'd0;
            m_dir = 1'b1; m_phase = P_IDLE; m_door_left = 0;
        end else begin
            m_in = m_in | btn_in;
            m_up = m_up | (btn_up & 8'h7f);
            m_dn = m_dn | (btn_down & 8'hfe);
            if ((m_phase == P_CHECK && open_now) || m_phase == P_DOOR) begin
                m_in[f] = 1'b0;
                if (m_dir) m_up[f] = 1'b0;
                else       m_dn[f] = 1'b0;
            end
            case (m_phase)
                P_IDLE: if (any_p) m_phase = P_CHECK;
                P_CHECK: begin
                    if (open_now) begin m_phase = P_DOOR; m_door_left = DC; end
                    else if (ahead_p) m_phase = P_STEP;
                    else if (any_p) m_dir = ~m_dir;
                    else m_phase = P_IDLE;
                end
                P_STEP: m_phase = P_CHECK;
                default: begin
                    m_door_left--;
                    if (m_door_left == 0) m_phase = P_CHECK;
                end
            endcase
        end
        m_floor = nf;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        check("model", 32'({call_in, call_up, call_down, direction, move, door_open, idle}),
              32'({m_in, m_up, m_dn, m_dir, m_phase == P_STEP, m_phase == P_DOOR, m_phase == P_IDLE}));
        check("floor", 32'(floor), 32'(m_floor));
    endtask

    task automatic do_reset(input logic [2:0] f);
        reset = 1'b1; floor_set_en = 1'b1; floor_set_val = f;
        cycle(); cycle();
        reset = 1'b0; floor_set_en = 1'b0;
        btn_in = 8'd0; btn_up = 8'd0; btn_down = 8'd0;
    endtask

    // Trace of one run until idle.
    int n_moves, n_door, first_door, first_flip, door_bad;
    bit reached;
    int move_cyc[$];

    task automatic run_trace(input int budget, input bit press_door);
        bit dir0;
        dir0 = direction;
        n_moves = 0; n_door = 0; first_door = 0; first_flip = 0; door_bad = 0; reached = 0;
        move_cyc.delete();
        for (int c = 1; c <= budget; c++) begin
            cycle();
            if (move) begin n_moves++; move_cyc.push_back(c); end
            if (door_open) begin
                n_door++;
                if (first_door == 0) first_door = c;
                if (call_in[floor]) door_bad = 1;
            end
            if (direction != dir0 && first_flip == 0) first_flip = c;
            if (press_door && door_open) begin
                btn_in = 8'd1 << floor;
                btn_up = direction ? 8'd1 << floor : 8'd0;
                btn_down = direction ? 8'd0 : 8'd1 << floor;
            end else begin
                btn_in = 8'd0; btn_up = 8'd0; btn_down = 8'd0;
            end
            if (idle) begin reached = 1; break; end
        end
        check("reached_idle", 32'(reached), 32'd1);
    endtask

    typedef struct {
        logic [7:0] bi, bu, bd;
        logic [7:0] ei, eu, ed;
    } vec_t;
    vec_t vecs[5];

    initial begin
        vecs[0] = '{8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
        vecs[1] = '{8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00};
        vecs[2] = '{8'h00, 8'hff, 8'hff, 8'h00, 8'h7f, 8'hfe};
        vecs[3] = '{8'h81, 8'h02, 8'h40, 8'h81, 8'h02, 8'h40};
        vecs[4] = '{8'h00, 8'h7f, 8'h00, 8'h00, 8'h7f, 8'h00};

        // Reset with buttons active.
        btn_in = 8'hff; btn_up = 8'hff; btn_down = 8'hff;
        do_reset(3'd0);
        check("rst_calls", 32'({call_in, call_up, call_down}), 32'd0);
        check("rst_flags", 32'({direction, move, door_open, idle}), 32'b1001);
        cycle();
        check("rst_after_calls", 32'({call_in, call_up, call_down}), 32'd0);

        // Table: one-edge press from IDLE, check latched/masked calls.
        for (int k = 0; k < 5; k++) begin
            do_reset(3'd0);
            btn_in = vecs[k].bi; btn_up = vecs[k].bu; btn_down = vecs[k].bd;
            cycle();
            btn_in = 8'd0; btn_up = 8'd0; btn_down = 8'd0;
            check($sformatf("vec%0d_calls", k), 32'({call_in, call_up, call_down}),
                  32'({vecs[k].ei, vecs[k].eu, vecs[k].ed}));
            check($sformatf("vec%0d_idle", k), 32'(idle), 32'd1);
        end
        // Masked-only presses never leave IDLE.
        do_reset(3'd2);
        btn_up = 8'h80; btn_down = 8'h01;
        cycle(); cycle(); cycle();
        btn_up = 8'd0; btn_down = 8'd0;
        check("mask_idle", 32'({idle, call_up, call_down}), 32'h10000);

        // Single car call from floor 0 to floor 3.
        do_reset(3'd0);
        btn_in = 8'h08;
        cycle();
        btn_in = 8'd0;
        check("car_latch", 32'(call_in), 32'h08);
        run_trace(60, 1'b0);
        check("car_moves", 32'(n_moves), 32'd3);
        if (n_moves == 3) begin
            check("car_gap1", 32'(move_cyc[1] - move_cyc[0]), 32'd2);
            check("car_gap2", 32'(move_cyc[2] - move_cyc[1]), 32'd2);
        end
        check("car_door", 32'(n_door), 32'(DC));
        check("car_door_clr", 32'(door_bad), 32'd0);
        check("car_floor", 32'(floor), 32'd3);
        check("car_calls", 32'(call_in), 32'd0);

        // Reversal: floor 5, heading up, only a down call at 2.
        do_reset(3'd5);
        btn_down = 8'h04;
        cycle();
        btn_down = 8'd0;
        run_trace(60, 1'b0);
        check("rev_flip_cyc", 32'(first_flip), 32'd2);
        check("rev_first_move", 32'(move_cyc.size() > 0 ? move_cyc[0] : 0), 32'd3);
        check("rev_moves", 32'(n_moves), 32'd3);
        check("rev_floor", 32'(floor), 32'd2);
        check("rev_call_down", 32'(call_down), 32'd0);
        check("rev_door", 32'(n_door), 32'(DC));

        // Opposite hall call at the current floor.
        do_reset(3'd4);
        btn_down = 8'h10;
        cycle();
        btn_down = 8'd0;
        run_trace(40, 1'b0);
        check("opp_moves", 32'(n_moves), 32'd0);
        check("opp_flip_cyc", 32'(first_flip), 32'd2);
        check("opp_door_cyc", 32'(first_door), 32'd3);
        check("opp_dir", 32'(direction), 32'd0);
        check("opp_call_down", 32'(call_down), 32'd0);

        // Presses of the served bits during DOOR do not cause a second stop.
        do_reset(3'd0);
        btn_in = 8'h08;
        cycle();
        btn_in = 8'd0;
        run_trace(60, 1'b1);
        check("dp_door", 32'(n_door), 32'(DC));
        check("dp_calls", 32'({call_in, call_up}), 32'd0);

        // Reset while move is high.
        do_reset(3'd0);
        btn_in = 8'h80; btn_up = 8'h10;
        cycle();
        btn_in = 8'd0; btn_up = 8'd0;
        reached = 0;
        for (int c = 0; c < 10 && !move; c++) cycle();
        check("ms_saw_move", 32'(move), 32'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("ms_flags", 32'({direction, move, door_open, idle}), 32'b1001);
        check("ms_calls", 32'({call_in, call_up, call_down}), 32'd0);

        // Random traffic against the model.
        do_reset(3'($urandom_range(0, 7)));
        for (int c = 0; c < 4000; c++) begin
            int r;
            btn_in = 8'd0; btn_up = 8'd0; btn_down = 8'd0;
            r = int'($urandom_range(0, 9));
            if (r == 0) btn_in[$urandom_range(0, 7)] = 1'b1;
            if (r == 1) btn_up[$urandom_range(0, 7)] = 1'b1;
            if (r == 2) btn_down[$urandom_range(0, 7)] = 1'b1;
            reset = ($urandom_range(0, 499) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
